// File: rtl/vcd_replay_reader.sv
// Replays buffered (time, value) records onto sig_out when scaled replay time reaches each timestamp.
// Build option: define REPLAY_STALL_EN to freeze replay time while starved of records before the last one.
module vcd_replay_reader #(
   parameter int DATA_W = 8,
   parameter int TS_W   = 16,
   parameter int SCALE  = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              rec_valid,
   output logic              rec_ready,
   input  logic [TS_W-1:0]   rec_time,
   input  logic [DATA_W-1:0] rec_value,
   input  logic              rec_last,
   output logic [DATA_W-1:0] sig_out,
   output logic              sig_strobe,
   output logic [TS_W-1:0]   now,
   output logic              busy,
   output logic              done,
   output logic              late_err
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = AW + 1;
   localparam int PW    = (SCALE > 1) ? $clog2(SCALE) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t              state_r, next_state_s;
   logic [TS_W-1:0]     mem_time  [DEPTH];
   logic [DATA_W-1:0]   mem_value [DEPTH];
   logic                mem_last  [DEPTH];
   logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]       count_r;
   logic [PW-1:0]       presc_r;
   logic [TS_W-1:0]     now_r;
   logic [DATA_W-1:0]   sig_out_r;
   logic                sig_strobe_r, late_err_r;
   logic                full_s, empty_s, accept_s, apply_s, last_apply_s, stall_s, advance_s;

   assign full_s       = (count_r == CW'(DEPTH));
   assign empty_s      = (count_r == {CW{1'b0}});
   assign rec_ready    = !full_s && (state_r != DONE);
   assign accept_s     = rec_valid && rec_ready;
   assign apply_s      = (state_r == RUN) && !empty_s && (mem_time[rd_ptr_r] <= now_r);
   assign last_apply_s = apply_s && mem_last[rd_ptr_r];
   assign advance_s    = (state_r == RUN) && !last_apply_s && !stall_s;

`ifdef REPLAY_STALL_EN
   logic last_seen_r;

   // Remembers that the final record has entered the buffer, so starvation can stop stalling time.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_seen_r <= 1'b0;
      end else if (last_apply_s || (state_r == DONE)) begin
         last_seen_r <= 1'b0;
      end else if (accept_s && rec_last) begin
         last_seen_r <= 1'b1;
      end
   end

   assign stall_s = empty_s && !last_seen_r;
`else
   assign stall_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    if (start) next_state_s = RUN;  else next_state_s = IDLE;
         RUN:     if (last_apply_s) next_state_s = DONE; else next_state_s = RUN;
         DONE:    if (start) next_state_s = IDLE; else next_state_s = DONE;
         default: next_state_s = IDLE;
      endcase
   end

   // Record storage; contents are don't-care until written, so no reset needed.
   always_ff @(posedge clock) begin
      if (accept_s) begin
         mem_time[wr_ptr_r]  <= rec_time;
         mem_value[wr_ptr_r] <= rec_value;
         mem_last[wr_ptr_r]  <= rec_last;
      end
   end

   // Buffer pointers, replay time base and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         count_r      <= {CW{1'b0}};
         presc_r      <= {PW{1'b0}};
         now_r        <= {TS_W{1'b0}};
         sig_out_r    <= {DATA_W{1'b0}};
         sig_strobe_r <= 1'b0;
         late_err_r   <= 1'b0;
      end else begin
         sig_strobe_r <= apply_s;
         if (apply_s) begin
            sig_out_r <= mem_value[rd_ptr_r];
            if (mem_time[rd_ptr_r] < now_r) late_err_r <= 1'b1;
         end
         // Finishing the trace flushes anything queued behind the last record.
         if (last_apply_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
         end else begin
            if (accept_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (apply_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({accept_s, apply_s})
               2'b10:   count_r <= count_r + CW'(1);
               2'b01:   count_r <= count_r - CW'(1);
               default: count_r <= count_r;
            endcase
         end
         if (advance_s) begin
            if (presc_r == PW'(SCALE - 1)) begin
               presc_r <= {PW{1'b0}};
               if (now_r != {TS_W{1'b1}}) now_r <= now_r + TS_W'(1);
            end else begin
               presc_r <= presc_r + PW'(1);
            end
         end
         if ((state_r == DONE) && start) begin
            presc_r    <= {PW{1'b0}};
            now_r      <= {TS_W{1'b0}};
            late_err_r <= 1'b0;
         end
      end
   end

   assign sig_out    = sig_out_r;
   assign sig_strobe = sig_strobe_r;
   assign now        = now_r;
   assign late_err   = late_err_r;
   assign busy       = (state_r == RUN);
   assign done       = (state_r == DONE);

endmodule

// File: tb/tb_vcd_replay_reader.sv
// Bench for vcd_replay_reader: directed and random traces checked against a cycle-level apply-time model.
module tb_vcd_replay_reader;

   localparam int DATA_W = 8;
   localparam int TS_W   = 16;
   localparam int SCALE  = 10;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [TS_W-1:0]   ts;
      logic [DATA_W-1:0] val;
      logic              last;
   } rec_t;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              rec_valid = 1'b0;
   logic              rec_ready;
   logic [TS_W-1:0]   rec_time = '0;
   logic [DATA_W-1:0] rec_value = '0;
   logic              rec_last = 1'b0;
   logic [DATA_W-1:0] sig_out;
   logic              sig_strobe;
   logic [TS_W-1:0]   now;
   logic              busy, done, late_err;

   int   n_assert = 0;
   int   n_fail = 0;
   rec_t pre_q[$];
   rec_t extra_q[$];

   vcd_replay_reader #(.DATA_W(DATA_W), .TS_W(TS_W), .SCALE(SCALE), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .rec_valid(rec_valid),
      .rec_ready(rec_ready), .rec_time(rec_time), .rec_value(rec_value), .rec_last(rec_last),
      .sig_out(sig_out), .sig_strobe(sig_strobe), .now(now), .busy(busy), .done(done),
      .late_err(late_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t mk(input int ts, input int val, input bit last);
      rec_t r;
      r.ts = TS_W'(ts);
      r.val = DATA_W'(val);
      r.last = last;
      return r;
   endfunction

   task automatic offer(input rec_t r);
      rec_valid = 1'b1;
      rec_time  = r.ts;
      rec_value = r.val;
      rec_last  = r.last;
   endtask

   // Called at a negedge; record is taken at the following posedge.
   task automatic load_rec(input rec_t r);
      chk("preload_ready", 32'(rec_ready), 32'd1);
      offer(r);
      @(negedge clock);
      rec_valid = 1'b0;
   endtask

   task automatic go_idle();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_now", 32'(now), 32'd0);
      chk("idle_late", 32'(late_err), 32'd0);
      chk("idle_ready", 32'(rec_ready), 32'd1);
   endtask

   // Record i is applied in RUN cycle max(a[i-1]+1, ts*SCALE); now during cycle k is k/SCALE.
   task automatic run_trace();
      rec_t all[$];
      int   a[$];
      int   prev, ai, k, idx, n;
      bit   exp_late, pending_acc, ready_seen, full_pre;
      all = {pre_q, extra_q};
      prev = -1;
      exp_late = 1'b0;
      foreach (all[i]) begin
         ai = int'(all[i].ts) * SCALE;
         if (ai < prev + 1) ai = prev + 1;
         if (ai / SCALE > int'(all[i].ts)) exp_late = 1'b1;
         a.push_back(ai);
         prev = ai;
      end
      n = a.size();
      full_pre = (pre_q.size() == DEPTH);
      @(negedge clock);
      foreach (pre_q[i]) load_rec(pre_q[i]);
      if (extra_q.size() > 0) begin
         offer(extra_q[0]);
         #1;
         chk("full_ready", 32'(rec_ready), 32'd0);
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("run_busy", 32'(busy), 32'd1);
      k = 0;
      idx = 0;
      pending_acc = 1'b0;
      ready_seen = 1'b0;
      while (k < 400) begin
         if (sig_strobe) begin
            if (idx < n) begin
               chk("strobe_cycle", 32'(k - 1), 32'(a[idx]));
               chk("strobe_value", 32'(sig_out), 32'(all[idx].val));
            end
            idx++;
         end
         if (pending_acc) begin
            void'(extra_q.pop_front());
            pending_acc = 1'b0;
         end
         if (extra_q.size() > 0) begin
            offer(extra_q[0]);
            if (rec_ready) begin
               pending_acc = 1'b1;
               if (!ready_seen && full_pre) chk("ready_reassert", 32'(k), 32'(a[0] + 1));
               ready_seen = 1'b1;
            end
         end else begin
            rec_valid = 1'b0;
         end
         if (done) break;
         @(negedge clock);
         k++;
      end
      rec_valid = 1'b0;
      chk("strobe_count", 32'(idx), 32'(n));
      chk("trace_done", 32'(done), 32'd1);
      chk("trace_busy", 32'(busy), 32'd0);
      chk("trace_now", 32'(now), 32'(a[n-1] / SCALE));
      chk("trace_late", 32'(late_err), 32'(exp_late));
      chk("done_ready", 32'(rec_ready), 32'd0);
      pre_q.delete();
      extra_q.delete();
   endtask

   initial begin
      int n;
      #12;
      chk("rst_sig", 32'(sig_out), 32'd0);
      chk("rst_strobe", 32'(sig_strobe), 32'd0);
      chk("rst_now", 32'(now), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_late", 32'(late_err), 32'd0);
      chk("rst_ready", 32'(rec_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;

      // Basic two-record trace.
      pre_q = {mk(3, 8'hA5, 1'b0), mk(5, 8'h3C, 1'b1)};
      run_trace();
      go_idle();

      // Full buffer plus one record offered while full.
      pre_q = {mk(1, 1, 1'b0), mk(2, 2, 1'b0), mk(3, 3, 1'b0), mk(4, 4, 1'b0)};
      extra_q = {mk(6, 5, 1'b1)};
      run_trace();
      go_idle();

      // Equal timestamps apply on consecutive cycles.
      pre_q = {mk(2, 8'h61, 1'b0), mk(2, 8'h62, 1'b1)};
      run_trace();
      chk("eq_final", 32'(sig_out), 32'h62);
      go_idle();

      // Starvation: start empty, feed the last record late.
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
`ifdef REPLAY_STALL_EN
      repeat (50) @(negedge clock);
      chk("stall_now", 32'(now), 32'd0);
`else
      for (int i = 0; i < 100 && now != TS_W'(4); i++) @(negedge clock);
      chk("starve_now4", 32'(now), 32'd4);
`endif
      offer(mk(1, 8'h11, 1'b1));
      @(negedge clock);
      rec_valid = 1'b0;
      for (int i = 0; i < 100 && !done; i++) @(negedge clock);
      chk("starve_done", 32'(done), 32'd1);
      chk("starve_sig", 32'(sig_out), 32'h11);
`ifdef REPLAY_STALL_EN
      chk("starve_late", 32'(late_err), 32'd0);
      chk("starve_end_now", 32'(now), 32'd1);
`else
      chk("starve_late", 32'(late_err), 32'd1);
      chk("starve_end_now", 32'(now), 32'd4);
`endif
      go_idle();

      // Random traces, timestamps not necessarily ordered.
      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++)
            pre_q.push_back(mk(int'($urandom_range(0, 8)), int'($urandom_range(0, 255)), i == n - 1));
         run_trace();
         go_idle();
      end

      // Asynchronous reset in the middle of a replay with records buffered.
      @(negedge clock);
      load_rec(mk(9, 8'h21, 1'b0));
      load_rec(mk(9, 8'h22, 1'b1));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (20) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_sig", 32'(sig_out), 32'd0);
      chk("arst_now", 32'(now), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ready", 32'(rec_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_busy", 32'(busy), 32'd0);
      pre_q = {mk(0, 8'h77, 1'b1)};
      run_trace();
      chk("post_rst_sig", 32'(sig_out), 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
